spi_slv16: RTL

Synthesizable 16-bit SPI responder: the slave end of the link driven by the team's 16-bit SPI master. It samples SS_n, SCLK and MOSI in the system clock domain, returns a preloaded 16-bit word on MISO, and presents the received 16-bit command with a one-cycle ready pulse. It replaces behavioural slave models in system benches and serves as the FPGA-side command port for off-board controllers.

---
 rtl/spi_slv16_pkg.sv | 16 +
 rtl/spi_slv16_if.sv | 24 ++
 rtl/spi_slv16_edge_sync.sv | 25 ++
 rtl/spi_slv16.sv | 104 ++++++++++
 4 files changed

// File: rtl/spi_slv16_pkg.sv
// spi_slv16 shared types and constants.
// Frame length and bit-counter sizing live here.
package spi_slv_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

endpackage

// File: rtl/spi_slv16_if.sv
// SPI pin bundle between an SPI master and spi_slv16.
// Master drives select/clock/data-out, slave drives MISO.
interface spi_slv16_if;

  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (
    output SS_n,
    output SCLK,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SS_n,
    input  SCLK,
    input  MOSI,
    output MISO
  );

endinterface

// File: rtl/spi_slv16_edge_sync.sv
// Synchronizer chain plus history flop for one async pin.
// Chain is left unreset so a held pin never fakes an edge.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    r_hist <= r_sync[SYNC_STAGES-1];
  end

  assign o_lvl  = r_sync[SYNC_STAGES-1];
  assign o_rise = o_lvl & ~r_hist;
  assign o_fall = ~o_lvl & r_hist;

endmodule

// File: rtl/spi_slv16.sv
// 16-bit SPI responder: returns tx_buf on MISO, captures
// the MOSI command and flags good or malformed frames.
import spi_slv_pkg::*;

module spi_slv16 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_slv16_if.slave         spi,
  input  logic [15:0]        tx_data,
  input  logic               tx_ld,
  output logic [15:0]        rx_data,
  output logic               rdy,
  output logic               frm_err
);

  localparam logic [0:0] S_IDLE  = IDLE;
  localparam logic [0:0] S_SHIFT = SHIFT;

  logic w_ss_lvl, w_ss_rise, w_ss_fall;
  logic w_sck_lvl, w_sck_rise, w_sck_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk    (clk),
    .i_d    (spi.SS_n),
    .o_lvl  (w_ss_lvl),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clk    (clk),
    .i_d    (spi.SCLK),
    .o_lvl  (w_sck_lvl),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .clk    (clk),
    .i_d    (spi.MOSI),
    .o_lvl  (w_mosi),
    .o_rise (w_mosi_rise),
    .o_fall (w_mosi_fall)
  );

  assign w_unused = ^{w_ss_lvl, w_sck_lvl, w_sck_fall,
                      w_mosi_rise, w_mosi_fall};

  logic [0:0]            r_state;
  logic [15:0]           r_tx_buf;
  logic [FRAME_BITS-1:0] r_shft;
  logic [CNT_W-1:0]      r_bit_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tx_buf  <= '0;
      r_shft    <= '0;
      r_bit_cnt <= '0;
      rx_data   <= '0;
      rdy       <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      if (tx_ld) begin
        r_tx_buf <= tx_data;
      end
      unique case (r_state)
        S_IDLE: begin
          if (w_ss_fall) begin
            r_state   <= S_SHIFT;
            r_shft    <= tx_ld ? tx_data : r_tx_buf;
            r_bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (w_ss_rise) begin
            r_state <= S_IDLE;
            if (r_bit_cnt == CNT_FULL) begin
              rx_data <= r_shft;
              rdy     <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
          end else if (w_sck_rise) begin
            r_shft <= {r_shft[FRAME_BITS-2:0], w_mosi};
            // Saturate so over-long frames can never wrap to 16.
            if (r_bit_cnt != CNT_SAT) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign spi.MISO = (r_state == S_SHIFT) ? r_shft[FRAME_BITS-1] : 1'b0;

endmodule
